// File: rtl/rr_arbiter_fsm.sv
// N-channel round-robin arbiter with bounded grant tenure and idle-free hand-off.
// Optional ARB_LOCK_EN adds a lock input that suppresses forced rotation of the current owner.
module rr_arbiter_fsm #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 8,
    parameter int IW       = $clog2(N)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [N-1:0]  req,
`ifdef ARB_LOCK_EN
    input  logic          lock,
`endif
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_id
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [7:0] HOLD = 8'(HOLD_MAX);

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   cur_q, cur_d;
    logic [7:0]      tenure_q, tenure_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [IW-1:0]   gnt_id_q, gnt_id_d;
    logic [N-1:0]    others;
    logic            grant_new;
    logic            lock_on;

    // First set bit of r scanning p, p+1, ..., wrapping modulo N.
    function automatic logic [IW-1:0] search(input logic [N-1:0] r, input logic [IW-1:0] p);
        logic [IW-1:0] res;
        logic          found;
        int            idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(p) + i) % N;
            if (!found && r[idx]) begin
                res   = IW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] c);
        return (int'(c) == N - 1) ? '0 : c + 1'b1;
    endfunction

`ifdef ARB_LOCK_EN
    assign lock_on = lock;
`else
    assign lock_on = 1'b0;
`endif

    assign others = req & ~(N'(1) << cur_q);

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        tenure_d    = tenure_q;
        grant_new   = 1'b0;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    cur_d     = search(req, ptr_q);
                    grant_new = 1'b1;
                end
            end
            GRANT: begin
                if (!req[cur_q]) begin
                    // Owner released: hand off on the same edge if anyone else waits.
                    if (|req) begin
                        cur_d     = search(req, ptr_q);
                        grant_new = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        tenure_d = '0;
                    end
                end else if (|others && tenure_q == HOLD && !lock_on) begin
                    cur_d     = search(others, ptr_q);
                    grant_new = 1'b1;
                end else if (tenure_q != HOLD) begin
                    tenure_d = tenure_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant_new) begin
            state_d  = GRANT;
            tenure_d = 8'd1;
            ptr_d    = next_ptr(cur_d);
        end
        if (state_d == GRANT) begin
            gnt_d       = N'(1) << cur_d;
            gnt_valid_d = 1'b1;
            gnt_id_d    = cur_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cur_q       <= '0;
            tenure_q    <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            tenure_q    <= tenure_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_rr_arbiter_fsm.sv
// Bench for rr_arbiter_fsm (N=4, HOLD_MAX=4): vector table through a scoreboard queue,
// plus hand-written reset, mid-grant reset and (with ARB_LOCK_EN) lock sequences.
module tb_rr_arbiter_fsm;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
`ifdef ARB_LOCK_EN
    logic          lock  = 1'b0;
`endif

    rr_arbiter_fsm #(.N(N), .HOLD_MAX(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] gnt;
        string        nm;
    } vec_t;

    vec_t         tbl[$];
    logic [N-1:0] exp_q[$];
    string        nm_q[$];
    int           n_cmp = 0;
    int           n_err = 0;

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] g, input string nm, input int cnt);
        vec_t v;
        for (int i = 0; i < cnt; i++) begin
            v.req = r;
            v.gnt = g;
            v.nm  = nm;
            tbl.push_back(v);
        end
    endtask

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_out(input string nm, input logic [N-1:0] e);
        int eid;
        eid = 0;
        for (int i = 0; i < N; i++) if (e[i]) eid = i;
        cmp({nm, ".gnt"},       int'(gnt),       int'(e));
        cmp({nm, ".gnt_valid"}, int'(gnt_valid), int'(|e));
        cmp({nm, ".gnt_id"},    int'(gnt_id),    eid);
    endtask

    // Drive req away from the edge, queue the expectation, check 1 time unit after the edge.
    task automatic step(input logic [N-1:0] r, input logic [N-1:0] e, input string nm);
        req = r;
        exp_q.push_back(e);
        nm_q.push_back(nm);
        @(posedge clock);
        #1;
        if (exp_q.size() == 0) begin
            cmp("scoreboard_empty", 1, 0);
        end else begin
            check_out(nm_q.pop_front(), exp_q.pop_front());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Fairness under full load: 0,1,2,3,0, each 4 cycles, no gaps.
        add(4'b1111, 4'b0001, "fair_ch0", 4);
        add(4'b1111, 4'b0010, "fair_ch1", 4);
        add(4'b1111, 4'b0100, "fair_ch2", 4);
        add(4'b1111, 4'b1000, "fair_ch3", 4);
        add(4'b1111, 4'b0001, "fair_wrap", 1);
        // Single requester: hand-off from ch0 then indefinite hold.
        add(4'b0100, 4'b0100, "single_ch2", 20);
        add(4'b0000, 4'b0000, "single_idle", 2);
        // Hand-off: ch1 granted from ptr=3, drop req[1] with ch0/ch3 pending -> ch3.
        add(4'b0010, 4'b0010, "handoff_get1", 1);
        add(4'b1011, 4'b0010, "handoff_hold1", 1);
        add(4'b1001, 4'b1000, "handoff_to3", 1);
        add(4'b0000, 4'b0000, "handoff_idle", 1);
        // Withdrawn request is never granted.
        add(4'b0110, 4'b0010, "withdraw_get1", 1);
        add(4'b0010, 4'b0010, "withdraw_hold1", 2);
        add(4'b0000, 4'b0000, "withdraw_idle", 1);
        // Saturated tenure: a late competitor forces rotation on the next edge.
        add(4'b0001, 4'b0001, "sat_hold0", 6);
        add(4'b0011, 4'b0010, "sat_forced1", 1);
        add(4'b0011, 4'b0010, "sat_stay1", 1);
        add(4'b0000, 4'b0000, "sat_idle", 1);

        // Reset held with all requests asserted.
        req = 4'b1111;
        repeat (3) @(posedge clock);
        #1;
        check_out("reset_hold", 4'b0000);
        @(negedge clock);
        reset = 1'b1;

        foreach (tbl[i]) step(tbl[i].req, tbl[i].gnt, tbl[i].nm);

        // Mid-grant asynchronous reset: gnt must drop before the next edge.
        step(4'b0010, 4'b0010, "midrst_get1");
        #2;
        reset = 1'b0;
        #1;
        check_out("midrst_async", 4'b0000);
        @(negedge clock);
        req   = 4'b1010;
        reset = 1'b1;
        step(4'b1010, 4'b0010, "midrst_restart");
        step(4'b0000, 4'b0000, "midrst_idle");

`ifdef ARB_LOCK_EN
        // ptr=2 here, so req=0011 grants ch0; lock keeps it past the tenure limit.
        lock = 1'b1;
        for (int i = 0; i < 12; i++) step(4'b0011, 4'b0001, "lock_hold0");
        lock = 1'b0;
        step(4'b0011, 4'b0010, "lock_drop_to1");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
